qm_ctx_state_unit: RTL and testbench

- Per-context probability-state manager for the QM/MQ arithmetic coder.
- Holds a state index (0..46) and an MPS bit for each of NUM_CTX contexts.
- Answers coder lookups with Qe, MPS and index.
- Applies LPS/MPS-renorm state transitions from the fixed 47-entry Qe/NMPS/NLPS/SWITCH probability table.
- Sits between the context modeller and the interval/renormalisation datapath.
- Replaces the raw table lookup with stateful, multi-context, self-initialising operation.

---
 rtl/qm_ctx_state_unit.sv | 193 +++++++++++++++++++
 tb/tb_qm_ctx_state_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/qm_ctx_state_unit.sv
// qm_ctx_state_unit: per-context QM/MQ probability-state manager.
// Every context holds a 6-bit state index and an MPS bit. A sweep after reset
// or clr loads the initial state. After that, each cycle accepts one lookup
// and one update. A lookup and an update on the same context in the same
// cycle are bypassed, so the lookup sees the post-update state.
module qm_ctx_state_unit #(
   parameter int NUM_CTX  = 19,
   parameter int CTX_W    = 5,
   parameter int INIT_IDX = 0,
   parameter int INIT_MPS = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   output logic             ready,
   input  logic             lk_valid,
   input  logic [CTX_W-1:0] lk_cx,
   output logic             rsp_valid,
   output logic [15:0]      rsp_qe,
   output logic             rsp_mps,
   output logic [5:0]       rsp_idx,
   output logic             rsp_err,
   input  logic             upd_valid,
   input  logic [CTX_W-1:0] upd_cx,
   input  logic             upd_lps,
   input  logic             upd_renorm
);

   localparam logic [CTX_W:0]   NUM_CTX_V = (CTX_W+1)'(NUM_CTX);
   localparam logic [CTX_W-1:0] LAST_CX   = CTX_W'(NUM_CTX - 1);
   localparam logic [6:0]       INIT_WORD = {6'(INIT_IDX), 1'(INIT_MPS)};

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t           state_reg, state_next;
   logic [CTX_W-1:0] cnt_reg, cnt_next;
   logic [6:0]       ctx_mem [NUM_CTX];   // {idx[5:0], mps}

   logic             lk_in, upd_in, lk_acc, upd_acc;
   logic [CTX_W-1:0] lk_sel, upd_sel;
   logic [6:0]       upd_cur, upd_new, lk_state;
   logic [28:0]      upd_rom, lk_rom;

   // Probability table entry: {Qe[15:0], NMPS[5:0], NLPS[5:0], SWITCH}
   function automatic logic [28:0] prob_rom(input logic [5:0] idx);
      logic [28:0] e;
      case (idx)
         6'd0:  e = {16'h5601, 6'd1,  6'd1,  1'b1};
         6'd1:  e = {16'h3401, 6'd2,  6'd6,  1'b0};
         6'd2:  e = {16'h1801, 6'd3,  6'd9,  1'b0};
         6'd3:  e = {16'h0AC1, 6'd4,  6'd12, 1'b0};
         6'd4:  e = {16'h0521, 6'd5,  6'd29, 1'b0};
         6'd5:  e = {16'h0221, 6'd38, 6'd33, 1'b0};
         6'd6:  e = {16'h5601, 6'd7,  6'd6,  1'b1};
         6'd7:  e = {16'h5401, 6'd8,  6'd14, 1'b0};
         6'd8:  e = {16'h4801, 6'd9,  6'd14, 1'b0};
         6'd9:  e = {16'h3801, 6'd10, 6'd14, 1'b0};
         6'd10: e = {16'h3001, 6'd11, 6'd17, 1'b0};
         6'd11: e = {16'h2401, 6'd12, 6'd18, 1'b0};
         6'd12: e = {16'h1C01, 6'd13, 6'd20, 1'b0};
         6'd13: e = {16'h1601, 6'd29, 6'd21, 1'b0};
         6'd14: e = {16'h5601, 6'd15, 6'd14, 1'b1};
         6'd15: e = {16'h5401, 6'd16, 6'd14, 1'b0};
         6'd16: e = {16'h5101, 6'd17, 6'd15, 1'b0};
         6'd17: e = {16'h4801, 6'd18, 6'd16, 1'b0};
         6'd18: e = {16'h3801, 6'd19, 6'd17, 1'b0};
         6'd19: e = {16'h3401, 6'd20, 6'd18, 1'b0};
         6'd20: e = {16'h3001, 6'd21, 6'd19, 1'b0};
         6'd21: e = {16'h2801, 6'd22, 6'd19, 1'b0};
         6'd22: e = {16'h2401, 6'd23, 6'd20, 1'b0};
         6'd23: e = {16'h2201, 6'd24, 6'd21, 1'b0};
         6'd24: e = {16'h1C01, 6'd25, 6'd22, 1'b0};
         6'd25: e = {16'h1801, 6'd26, 6'd23, 1'b0};
         6'd26: e = {16'h1601, 6'd27, 6'd24, 1'b0};
         6'd27: e = {16'h1401, 6'd28, 6'd25, 1'b0};
         6'd28: e = {16'h1201, 6'd29, 6'd26, 1'b0};
         6'd29: e = {16'h1101, 6'd30, 6'd27, 1'b0};
         6'd30: e = {16'h0AC1, 6'd31, 6'd28, 1'b0};
         6'd31: e = {16'h09C1, 6'd32, 6'd29, 1'b0};
         6'd32: e = {16'h08A1, 6'd33, 6'd30, 1'b0};
         6'd33: e = {16'h0521, 6'd34, 6'd31, 1'b0};
         6'd34: e = {16'h0441, 6'd35, 6'd32, 1'b0};
         6'd35: e = {16'h02A1, 6'd36, 6'd33, 1'b0};
         6'd36: e = {16'h0221, 6'd37, 6'd34, 1'b0};
         6'd37: e = {16'h0141, 6'd38, 6'd35, 1'b0};
         6'd38: e = {16'h0111, 6'd39, 6'd36, 1'b0};
         6'd39: e = {16'h0085, 6'd40, 6'd37, 1'b0};
         6'd40: e = {16'h0049, 6'd41, 6'd38, 1'b0};
         6'd41: e = {16'h0025, 6'd42, 6'd39, 1'b0};
         6'd42: e = {16'h0015, 6'd43, 6'd40, 1'b0};
         6'd43: e = {16'h0009, 6'd44, 6'd41, 1'b0};
         6'd44: e = {16'h0005, 6'd45, 6'd42, 1'b0};
         6'd45: e = {16'h0001, 6'd45, 6'd43, 1'b0};
         default: e = {16'h5601, 6'd46, 6'd46, 1'b0};
      endcase
      return e;
   endfunction

   assign ready   = (state_reg == ST_RUN);
   assign lk_in   = ({1'b0, lk_cx}  < NUM_CTX_V);
   assign upd_in  = ({1'b0, upd_cx} < NUM_CTX_V);
   assign lk_sel  = lk_in  ? lk_cx  : '0;
   assign upd_sel = upd_in ? upd_cx : '0;
   // A clr in RUN takes priority and drops same-cycle traffic.
   assign lk_acc  = lk_valid  & ready & ~clr;
   assign upd_acc = upd_valid & ready & ~clr & upd_in;

   // Next state of the context being updated (LPS / MPS-renorm / hold)
   always_comb begin
      upd_cur = ctx_mem[upd_sel];
      upd_rom = prob_rom(upd_cur[6:1]);
      upd_new = upd_cur;
      if (upd_lps)
         upd_new = {upd_rom[6:1], upd_cur[0] ^ upd_rom[0]};
      else if (upd_renorm)
         upd_new = {upd_rom[12:7], upd_cur[0]};
   end

   // Lookup source with read-after-write bypass from the same-cycle update
   always_comb begin
      lk_state = (upd_acc && (upd_sel == lk_sel)) ? upd_new : ctx_mem[lk_sel];
      lk_rom   = prob_rom(lk_state[6:1]);
   end

   // FSM next state: sweep through all contexts, then run until clr
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_INIT: begin
            if (clr)
               cnt_next = '0;
            else if (cnt_reg == LAST_CX) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end else
               cnt_next = cnt_reg + 1'b1;
         end
         ST_RUN: begin
            if (clr) begin
               state_next = ST_INIT;
               cnt_next   = '0;
            end
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_INIT;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Context array: a sweep write during INIT, otherwise an accepted update
   always_ff @(posedge clk) begin
      if (state_reg == ST_INIT && !clr)
         ctx_mem[cnt_reg] <= INIT_WORD;
      else if (upd_acc)
         ctx_mem[upd_sel] <= upd_new;
   end

   // Registered lookup response, one cycle after acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_qe    <= '0;
         rsp_mps   <= 1'b0;
         rsp_idx   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= lk_acc;
         rsp_err   <= 1'b0;
         if (lk_acc) begin
            if (lk_in) begin
               rsp_qe  <= lk_rom[28:13];
               rsp_mps <= lk_state[0];
               rsp_idx <= lk_state[6:1];
            end else begin
               rsp_qe  <= '0;
               rsp_mps <= 1'b0;
               rsp_idx <= '0;
               rsp_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_qm_ctx_state_unit.sv
// Testbench for qm_ctx_state_unit. It applies fixed vectors, then random
// traffic checked against a rule-level model of the contexts, then
// clr/reset corner sequences.
module tb_qm_ctx_state_unit;
   localparam int NUM_CTX = 19;
   localparam int CTX_W   = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             ready;
   logic             lk_valid = 1'b0;
   logic [CTX_W-1:0] lk_cx = '0;
   logic             rsp_valid;
   logic [15:0]      rsp_qe;
   logic             rsp_mps;
   logic [5:0]       rsp_idx;
   logic             rsp_err;
   logic             upd_valid = 1'b0;
   logic [CTX_W-1:0] upd_cx = '0;
   logic             upd_lps = 1'b0;
   logic             upd_renorm = 1'b0;

   qm_ctx_state_unit #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .INIT_IDX(0), .INIT_MPS(0)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
      .lk_valid(lk_valid), .lk_cx(lk_cx),
      .rsp_valid(rsp_valid), .rsp_qe(rsp_qe), .rsp_mps(rsp_mps),
      .rsp_idx(rsp_idx), .rsp_err(rsp_err),
      .upd_valid(upd_valid), .upd_cx(upd_cx),
      .upd_lps(upd_lps), .upd_renorm(upd_renorm)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Probability table as plain data
   int qe_t [47] = '{'h5601,'h3401,'h1801,'h0AC1,'h0521,'h0221,'h5601,'h5401,'h4801,'h3801,
                     'h3001,'h2401,'h1C01,'h1601,'h5601,'h5401,'h5101,'h4801,'h3801,'h3401,
                     'h3001,'h2801,'h2401,'h2201,'h1C01,'h1801,'h1601,'h1401,'h1201,'h1101,
                     'h0AC1,'h09C1,'h08A1,'h0521,'h0441,'h02A1,'h0221,'h0141,'h0111,'h0085,
                     'h0049,'h0025,'h0015,'h0009,'h0005,'h0001,'h5601};
   int nmps_t [47] = '{1,2,3,4,5,38,7,8,9,10,11,12,13,29,15,16,17,18,19,20,21,22,23,24,25,26,
                       27,28,29,30,31,32,33,34,35,36,37,38,39,40,41,42,43,44,45,45,46};
   int nlps_t [47] = '{1,6,9,12,29,33,6,14,14,14,17,18,20,21,14,14,15,16,17,18,19,19,20,21,22,
                       23,24,25,26,27,28,29,30,31,32,33,34,35,36,37,38,39,40,41,42,43,46};
   int sw_t [47]   = '{1,0,0,0,0,0,1,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,
                       0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

   // Reference model: context contents and clocks left until ready
   int m_idx [NUM_CTX];
   int m_mps [NUM_CTX];
   int m_left;

   typedef struct {
      bit lv; int lcx; bit uv; int ucx; bit lps; bit ren;
      bit ev; int eqe; int emps; int eidx; bit eerr;
   } vec_t;
   vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_init();
      for (int i = 0; i < NUM_CTX; i++) begin
         m_idx[i] = 0;
         m_mps[i] = 0;
      end
      m_left = NUM_CTX;
   endtask

   // One clock with the given requests; the DUT is checked against the model.
   task automatic cycle(input bit lv, input int lcx, input bit uv, input int ucx,
                        input bit lps, input bit ren, input bit c);
      bit rdy, e_valid, e_err;
      int e_qe, e_idx, e_mps, s;
      lk_valid = lv;  lk_cx = lcx[CTX_W-1:0];
      upd_valid = uv; upd_cx = ucx[CTX_W-1:0];
      upd_lps = lps;  upd_renorm = ren; clr = c;
      rdy = (m_left == 0);
      e_valid = lv && rdy && !c;
      e_err = 0; e_qe = 0; e_idx = 0; e_mps = 0;
      if (uv && rdy && !c && ucx < NUM_CTX) begin
         s = m_idx[ucx];
         if (lps) begin
            if (sw_t[s] == 1) m_mps[ucx] = 1 - m_mps[ucx];
            m_idx[ucx] = nlps_t[s];
         end else if (ren) begin
            m_idx[ucx] = nmps_t[s];
         end
      end
      if (e_valid) begin
         if (lcx >= NUM_CTX) e_err = 1;
         else begin
            e_idx = m_idx[lcx];
            e_mps = m_mps[lcx];
            e_qe  = qe_t[e_idx];
         end
      end
      if (c) model_init();
      else if (!rdy) m_left--;
      @(posedge clk);
      #1;
      if (e_valid || (uv && rdy && !c))
         $display("txn lk=%0b cx=%0d upd=%0b cx=%0d lps=%0b ren=%0b -> v=%0b qe=%0d mps=%0b idx=%0d err=%0b",
                  lv, lcx, uv, ucx, lps, ren, rsp_valid, rsp_qe, rsp_mps, rsp_idx, rsp_err);
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      if (e_valid) begin
         check("rsp_qe",  32'(rsp_qe),  e_qe);
         check("rsp_mps", 32'(rsp_mps), e_mps);
         check("rsp_idx", 32'(rsp_idx), e_idx);
         check("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      check("ready", 32'(ready), 32'(m_left == 0));
      lk_valid = 0; upd_valid = 0; upd_lps = 0; upd_renorm = 0; clr = 0;
   endtask

   task automatic reset_and_check();
      lk_valid = 0; upd_valid = 0; clr = 0;
      rst_n = 1'b0;
      #1;
      check("reset_rsp_valid", 32'(rsp_valid), 0);
      check("reset_rsp_qe",    32'(rsp_qe), 0);
      check("reset_rsp_mps",   32'(rsp_mps), 0);
      check("reset_rsp_idx",   32'(rsp_idx), 0);
      check("reset_rsp_err",   32'(rsp_err), 0);
      check("reset_ready",     32'(ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_init();
   endtask

   task automatic sweep_lookups();
      for (int i = 0; i < NUM_CTX; i++) cycle(1, i, 0, 0, 0, 0, 0);
   endtask

   task automatic add(input bit lv, input int lcx, input bit uv, input int ucx, input bit lps,
                      input bit ren, input bit ev, input int eqe, input int emps, input int eidx,
                      input bit eerr);
      vecs.push_back('{lv, lcx, uv, ucx, lps, ren, ev, eqe, emps, eidx, eerr});
   endtask

   initial begin
      // Fixed vectors, applied from the all-initial state
      add(1, 3, 0, 0, 0, 0, 1, 22017, 0, 0, 0);
      add(0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
      add(1, 3, 0, 0, 0, 0, 1, 13313, 1, 1, 0);
      add(1, 4, 0, 0, 0, 0, 1, 22017, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0);
      add(1, 2, 0, 0, 0, 0, 1, 545, 0, 5, 0);
      add(1, 2, 1, 2, 0, 1, 1, 273, 0, 38, 0);
      add(1, 2, 1, 2, 0, 0, 1, 273, 0, 38, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      add(1, 5, 0, 0, 0, 0, 1, 1313, 0, 33, 0);
      add(1, 7, 1, 7, 1, 0, 1, 13313, 1, 1, 0);
      add(1, 9, 1, 8, 1, 0, 1, 22017, 0, 0, 0);
      add(1, 8, 0, 0, 0, 0, 1, 13313, 1, 1, 0);
      add(1, 19, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      add(1, 31, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      add(0, 0, 1, 19, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 31, 1, 1, 0, 0, 0, 0, 0);

      reset_and_check();
      for (int i = 0; i < NUM_CTX - 1; i++) cycle(0, 0, 0, 0, 0, 0, 0);
      check("ready_low_before_sweep_end", 32'(ready), 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      check("ready_after_sweep", 32'(ready), 1);

      foreach (vecs[i]) begin
         cycle(vecs[i].lv, vecs[i].lcx, vecs[i].uv, vecs[i].ucx, vecs[i].lps, vecs[i].ren, 0);
         check($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].ev));
         if (vecs[i].ev) begin
            check($sformatf("vec%0d_qe", i),  32'(rsp_qe),  vecs[i].eqe);
            check($sformatf("vec%0d_mps", i), 32'(rsp_mps), vecs[i].emps);
            check($sformatf("vec%0d_idx", i), 32'(rsp_idx), vecs[i].eidx);
            check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].eerr));
         end
      end
      sweep_lookups();

      // MPS-renorm chain on cx10 up to idx45, which must saturate
      for (int i = 0; i < 16; i++) cycle(0, 0, 1, 10, 0, 1, 0);
      cycle(1, 10, 0, 0, 0, 0, 0);
      check("sat_idx45", 32'(rsp_idx), 45);
      check("sat_qe1",   32'(rsp_qe), 1);

      // Random traffic against the model, including occasional clr
      for (int n = 0; n < 800; n++) begin
         bit c;
         c = ($urandom_range(0, 79) == 0);
         cycle($urandom_range(0, 3) != 0,
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, NUM_CTX - 1),
               $urandom_range(0, 3) != 0,
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6),
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, c);
      end
      while (m_left != 0) cycle(0, 0, 0, 0, 0, 0, 0);
      sweep_lookups();

      // clr with a simultaneous update, clr inside INIT, then reset mid-sweep
      cycle(0, 0, 1, 0, 1, 0, 0);
      cycle(1, 0, 1, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, 0);
      reset_and_check();
      for (int i = 0; i < NUM_CTX; i++) cycle(0, 0, 0, 0, 0, 0, 0);
      sweep_lookups();

      // Reset asserted while a lookup is in flight: no response may appear
      cycle(0, 0, 1, 1, 1, 0, 0);
      lk_valid = 1; lk_cx = 5'd1;
      #3;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("inflight_no_rsp", 32'(rsp_valid), 0);
      check("inflight_ready",  32'(ready), 0);
      lk_valid = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_init();
      for (int i = 0; i < NUM_CTX; i++) cycle(1, 1, 0, 0, 0, 0, 0);
      check("ready_after_reset", 32'(ready), 1);
      sweep_lookups();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
